fuzz_datapath_misr: RTL and testbench

- Parametrised successor of the single-instance fuzz datapath.
- Holds CH registered channels of width W, each updated by a selectable arithmetic mode.
- A control FSM brackets each run of DEPTH samples and compresses the channel state into a MISR signature.
- The block sits in the equivalence-fuzz harness: its wide concatenated output y is what the synthesis-vs-RTL identity check compares.

---
 rtl/fuzz_dp_pkg.sv | 29 ++
 rtl/fuzz_dp_channel.sv | 47 ++++
 rtl/fuzz_datapath_misr.sv | 132 +++++++++++++
 tb/tb_fuzz_datapath_misr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_dp_pkg.sv
// Shared types and helpers for the fuzz datapath with MISR signature.
// Holds the control state encoding, channel mode codes and the MISR step.
package fuzz_dp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_ADD  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_MAX  = 2'd3;

    // One MISR shift on a signature of sig_w bits (sig_w <= 64), carried in
    // 64-bit containers so any signature width can share this helper.
    function automatic logic [63:0] misr_step(input logic [63:0] sig,
                                              input logic [63:0] fold,
                                              input logic [63:0] poly,
                                              input int          sig_w);
        logic [63:0] mask;
        logic [63:0] fb;
        mask = (sig_w >= 64) ? {64{1'b1}} : ((64'd1 << sig_w) - 64'd1);
        fb   = sig[sig_w-1] ? poly : 64'd0;
        return ((sig << 1) ^ fb ^ fold) & mask;
    endfunction

endpackage

// File: rtl/fuzz_dp_channel.sv
// Next-value logic for one W-bit channel of the fuzz datapath.
// Optional build macro FUZZ_SAT_ADD_EN: add mode saturates at 2^W-1
// instead of wrapping.
module fuzz_dp_channel
    import fuzz_dp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_din,
    input  logic [W-1:0] i_ch,
    input  logic [W-1:0] i_nbr,
    input  logic [1:0]   i_mode,
    output logic [W-1:0] o_ch_next
);

`ifdef FUZZ_SAT_ADD_EN
    // Unsigned add on a W+1-bit sum, clamped to all-ones on carry out.
    function automatic logic [W-1:0] add_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction
`else
    // Unsigned add wrapping modulo 2^W.
    function automatic logic [W-1:0] add_op(input logic [W-1:0] a, input logic [W-1:0] b);
        return a + b;
    endfunction
`endif

    logic signed [W-1:0] w_din_s;
    logic signed [W-1:0] w_ch_s;

    assign w_din_s = i_din;
    assign w_ch_s  = i_ch;

    // Select the channel's next value according to the sample's mode.
    always_comb begin
        o_ch_next = i_ch;
        case (i_mode)
            MODE_PASS: o_ch_next = i_din;
            MODE_ADD:  o_ch_next = add_op(i_ch, i_din);
            MODE_XOR:  o_ch_next = i_din ^ i_nbr;
            default:   o_ch_next = (w_din_s > w_ch_s) ? i_din : i_ch;
        endcase
    end

endmodule

// File: rtl/fuzz_datapath_misr.sv
// CH-channel fuzz datapath: a run of up to DEPTH accepted samples updates
// the channels and compresses them into a MISR signature, bracketed by an
// IDLE/RUN/DONE control FSM. Optional macro FUZZ_SAT_ADD_EN (see channel).
module fuzz_datapath_misr
    import fuzz_dp_pkg::*;
#(
    parameter int               W     = 8,
    parameter int               CH    = 4,
    parameter int               DEPTH = 16,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    input  logic [CH*W-1:0]         din,
    output logic                    busy,
    output logic                    sig_valid,
    output logic [SIG_W+CH*W:0]     y
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [W-1:0]       r_ch [CH];
    logic [W-1:0]       w_ch_next [CH];
    logic [SIG_W-1:0]   w_fold_ch [CH];
    logic [SIG_W-1:0]   r_sig;
    logic [SIG_W-1:0]   w_sig_next;
    logic [SIG_W-1:0]   w_fold;
    logic [CNT_W-1:0]   r_cnt;
    logic [CH*W-1:0]    w_ch_flat;
    logic               w_accept;
    logic               w_clear;
    logic               w_busy;
    logic               w_sig_valid;

    // Per-channel next values; the xor-ring neighbour of channel g is g+1 mod CH.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        fuzz_dp_channel #(.W(W)) u_ch (
            .i_din     (din[g*W +: W]),
            .i_ch      (r_ch[g]),
            .i_nbr     (r_ch[(g + 1) % CH]),
            .i_mode    (mode),
            .o_ch_next (w_ch_next[g])
        );

        if (W >= SIG_W) begin : g_trunc
            assign w_fold_ch[g] = w_ch_next[g][SIG_W-1:0];
        end else begin : g_zext
            assign w_fold_ch[g] = {{(SIG_W-W){1'b0}}, w_ch_next[g]};
        end

        assign w_ch_flat[g*W +: W] = r_ch[g];
    end

    // Fold all next channel values into one signature-wide word.
    always_comb begin
        w_fold = '0;
        for (int i = 0; i < CH; i++) begin
            w_fold = w_fold ^ w_fold_ch[i];
        end
    end

    assign w_sig_next = SIG_W'(misr_step(64'(r_sig), 64'(w_fold), 64'(POLY), SIG_W));

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode: start only counts in IDLE, stop only in RUN.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        w_busy       = 1'b0;
        w_sig_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_clear      = 1'b1;
                end
            end
            RUN: begin
                w_busy   = 1'b1;
                w_accept = in_valid;
                if ((in_valid && (r_cnt == CNT_W'(DEPTH - 1))) || stop) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_busy       = 1'b1;
                w_sig_valid  = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Channel, signature and sample-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) r_ch[i] <= '0;
            r_sig <= SEED;
            r_cnt <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < CH; i++) r_ch[i] <= '0;
            r_sig <= SEED;
            r_cnt <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < CH; i++) r_ch[i] <= w_ch_next[i];
            r_sig <= w_sig_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign busy      = w_busy;
    assign sig_valid = w_sig_valid;
    assign y         = {r_sig, w_ch_flat, 1'b0};

endmodule

// File: tb/tb_fuzz_datapath_misr.sv
// Bench for fuzz_datapath_misr (W=8, CH=2, DEPTH=4, SIG_W=16): directed
// vector table, hand sequences and randomized traffic against a model.
module tb_fuzz_datapath_misr;

    localparam int          W     = 8;
    localparam int          CH    = 2;
    localparam int          DEPTH = 4;
    localparam int          SIG_W = 16;
    localparam logic [15:0] POLY  = 16'h1021;
    localparam logic [15:0] SEED  = 16'h0000;

`ifdef FUZZ_SAT_ADD_EN
    localparam logic [7:0]  ADD_CH0 = 8'hFF;
    localparam logic [15:0] S3      = 16'h0107;
    localparam logic [15:0] S4      = 16'h020E;
`else
    localparam logic [7:0]  ADD_CH0 = 8'h10;
    localparam logic [15:0] S3      = 16'h01E8;
    localparam logic [15:0] S4      = 16'h03D0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, in_valid;
    logic [1:0]  mode;
    logic [15:0] din;
    logic        busy, sig_valid;
    logic [32:0] y;

    int n_chk  = 0;
    int n_fail = 0;

    fuzz_datapath_misr #(
        .W(W), .CH(CH), .DEPTH(DEPTH), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .in_valid(in_valid), .din(din), .busy(busy), .sig_valid(sig_valid), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, sp, iv;
        logic [1:0]  md;
        logic [15:0] d;
        logic [7:0]  e_ch0, e_ch1;
        logic [15:0] e_sig;
        logic        e_busy, e_sv;
    } vec_t;

    vec_t tbl [16];

    // Behavioural model state
    logic [7:0]  mch [2];
    logic [15:0] msig;
    int          mphase;   // 0 idle, 1 in a run, 2 reporting signature
    int          mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic iv,
                         input logic [1:0] md, input logic [15:0] d);
        @(negedge clk);
        start = st; stop = sp; in_valid = iv; mode = md; din = d;
        @(posedge clk);
        #1;
    endtask

    function automatic int sx(input logic [7:0] v);
        return (v >= 8'd128) ? int'(v) - 256 : int'(v);
    endfunction

    task automatic model_reset();
        mch[0] = 8'h00; mch[1] = 8'h00; msig = SEED; mphase = 0; mcnt = 0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic iv,
                              input logic [1:0] md, input logic [15:0] d);
        logic [7:0]  old [2];
        logic [7:0]  di;
        logic [15:0] fold;
        int          s;
        if (mphase == 0) begin
            if (st) begin
                mphase = 1; mch[0] = 8'h00; mch[1] = 8'h00; msig = SEED; mcnt = 0;
            end
        end else if (mphase == 1) begin
            if (iv) begin
                old[0] = mch[0]; old[1] = mch[1];
                fold = 16'h0000;
                for (int i = 0; i < 2; i++) begin
                    di = d[i*8 +: 8];
                    case (md)
                        2'd0: mch[i] = di;
                        2'd1: begin
                            s = int'(old[i]) + int'(di);
`ifdef FUZZ_SAT_ADD_EN
                            if (s > 255) s = 255;
`endif
                            mch[i] = 8'(s % 256);
                        end
                        2'd2: mch[i] = di ^ old[(i + 1) % 2];
                        default: mch[i] = (sx(di) > sx(old[i])) ? di : old[i];
                    endcase
                    fold = fold ^ {8'h00, mch[i]};
                end
                msig = {msig[14:0], 1'b0} ^ (msig[15] ? POLY : 16'h0000) ^ fold;
                mcnt++;
            end
            if ((iv && mcnt == DEPTH) || sp) mphase = 2;
        end else begin
            mphase = 0;
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_y"},    64'(y),         64'({msig, mch[1], mch[0], 1'b0}));
        chk({tag, "_busy"}, 64'(busy),      64'(mphase != 0));
        chk({tag, "_sv"},   64'(sig_valid), 64'(mphase == 2));
    endtask

    task automatic step_model(input string tag, input logic st, input logic sp, input logic iv,
                              input logic [1:0] md, input logic [15:0] d);
        drive(st, sp, iv, md, d);
        model_step(st, sp, iv, md, d);
        model_check(tag);
    endtask

    initial begin
        int pulses;
        int pulse_k;

        //                st    sp    iv    md     d          ch0    ch1    sig       busy  sv
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h3333, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h0305, 8'h05, 8'h03, 16'h0006, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h05, 8'h03, 16'h0006, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h00F0, 8'hF0, 8'h00, 16'h00FC, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h0020, ADD_CH0, 8'h00, S3,   1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 8'h00, 8'h00, S4,       1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 8'h00, S4,       1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 2'd0, 16'h1111, 8'h00, 8'h00, S4,       1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'hF00F, 8'h0F, 8'hF0, 16'h00FF, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd2, 16'h0102, 8'hF2, 8'h0E, 16'h0102, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 2'd3, 16'h7F80, 8'hF2, 8'h7F, 16'h0289, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h1111, 8'hF2, 8'h7F, 16'h0289, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 16'h5555, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; mode = 2'd0; din = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("reset_y",    64'(y),         64'({SEED, 16'h0000, 1'b0}));
        chk("reset_busy", 64'(busy),      64'd0);
        chk("reset_sv",   64'(sig_valid), 64'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].iv, tbl[i].md, tbl[i].d);
            chk($sformatf("tbl%0d_y", i),    64'(y),
                64'({tbl[i].e_sig, tbl[i].e_ch1, tbl[i].e_ch0, 1'b0}));
            chk($sformatf("tbl%0d_busy", i), 64'(busy),      64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_sv", i),   64'(sig_valid), 64'(tbl[i].e_sv));
        end

        // Full-length run with gaps; a start during DONE must be ignored
        model_reset();
        step_model("len_start", 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        pulses = 0; pulse_k = -1;
        for (int k = 0; k < 12; k++) begin
            step_model($sformatf("len%0d", k), (k == 10), 1'b0, (k % 3 == 0),
                       2'($urandom_range(0, 3)), 16'($urandom));
            if (sig_valid) begin
                pulses++;
                pulse_k = k;
            end
            if (k < 10) chk($sformatf("len%0d_busy_hi", k), 64'(busy), 64'(k <= 9));
        end
        chk("len_pulses",  64'(pulses),  64'd1);
        chk("len_pulse_k", 64'(pulse_k), 64'd9);
        chk("len_idle",    64'(busy),    64'd0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            step_model("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 16'($urandom));
        end

        // Reset asserted between edges in the middle of a run
        step_model("mr_idle", 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        step_model("mr_idle2", 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        step_model("mr_start", 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        step_model("mr_acc0", 1'b0, 1'b0, 1'b1, 2'd0, 16'hA55A);
        step_model("mr_acc1", 1'b0, 1'b0, 1'b1, 2'd1, 16'h1234);
        @(negedge clk);
        in_valid = 1'b1; din = 16'hFFFF; mode = 2'd0; start = 1'b0; stop = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mr_y",    64'(y),         64'({SEED, 16'h0000, 1'b0}));
        chk("mr_busy", 64'(busy),      64'd0);
        chk("mr_sv",   64'(sig_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            step_model($sformatf("mr_after%0d", k), 1'b0, 1'b0, 1'b1, 2'd0, 16'h0F0F);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
